rle_stream_decoder: RTL and testbench
=====================================

RLE_STREAM_DECODER -- requirements
Module: rle_stream_decoder

Interface
REQ-001 SHALL have parameter COLOUR_BITS, default 6, colour field width in bits (1..8).
REQ-002 SHALL have parameter RUN_BITS, default 10, run-length field width in bits (2..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, input word buffer depth (power of 2, >=2).
REQ-004 SHALL have word width W = RUN_BITS+COLOUR_BITS: run in [W-1:COLOUR_BITS], colour in [COLOUR_BITS-1:0].
REQ-005 Ports SHALL be:
- clk  in  1  single clock, all logic posedge
- rstn  in  1  asynchronous active-low reset
- in_data  in  W  stream word from flash controller
- in_valid  in  1  in_data valid
- in_ready  out  1  decoder accepts word this cycle
- next_frame  in  1  one-cycle pulse, start of new frame
- next_pixel  in  1  one-cycle strobe, consume one displayed pixel
- colour  out  COLOUR_BITS  current pixel colour
- fetch_restart  out  1  one-cycle pulse, stream must restart at address 0
- underrun  out  1  sticky per-frame starvation flag
- frame_done  out  1  end-of-frame marker consumed

Function
REQ-006 Word transfer SHALL occur exactly when in_valid && in_ready at a clk edge.
REQ-007 in_ready SHALL be high only when the FIFO is not full and state is FILL or RUN.
REQ-008 States SHALL be IDLE, FILL, RUN, END; reset enters IDLE.
REQ-009 next_frame in any state SHALL flush the FIFO, clear run counter, clear underrun and frame_done, pulse fetch_restart the following cycle, and enter FILL.
REQ-010 FILL: first word popped SHALL load run counter and colour register and enter RUN; colour output 0 while in FILL.
REQ-011 RUN: on next_pixel, run counter SHALL decrement; when counter is 1, the next FIFO word SHALL be popped in the same cycle so the following pixel shows the new colour with zero bubble.
REQ-012 Popped word with run field 0 SHALL be an end-of-frame marker: enter END, frame_done=1, colour=0, in_ready=0.
REQ-013 Run value n (1..2^RUN_BITS-1) SHALL display exactly n next_pixel strobes of that colour.
REQ-014 Run exhaustion with FIFO empty SHALL set underrun, force colour 0 per further next_pixel, and load the next word as soon as one is written (write-through permitted).
REQ-015 next_pixel in FILL SHALL also set underrun.
REQ-016 Simultaneous FIFO write and pop SHALL be allowed at any occupancy except write when full; occupancy unchanged.
REQ-017 next_frame and next_pixel in the same cycle: next_frame SHALL win, next_pixel ignored.
REQ-018 IDLE: colour 0, in_ready 0, waits for next_frame.
REQ-019 colour, frame_done, underrun, fetch_restart SHALL be registered outputs.

Reset
REQ-020 rstn low SHALL immediately force: state IDLE, FIFO empty, colour 0, in_ready 0, fetch_restart 0, underrun 0, frame_done 0, run counter 0.
REQ-021 Reset mid-run SHALL discard all buffered words; no fetch_restart pulse until next next_frame.

Configuration
REQ-022 Macro RLE_DECODER_STATS_EN defined SHALL add output underrun_count [7:0]: count of next_pixel strobes served with colour forced by underrun, saturating at 255, cleared by reset and next_frame.
REQ-023 Without RLE_DECODER_STATS_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-024 Defaults; next_frame, feed words {run=3,col=0x2A},{run=2,col=0x15}, 5 next_pixel strobes -> colour 2A,2A,2A,15,15, no underrun.
REQ-025 Fill FIFO to 4 with in_valid held -> in_ready low at full; one pop -> in_ready high next cycle, 5th word accepted.
REQ-026 {run=1,col=0x3F}, then word with run=0 -> after one pixel frame_done=1, colour 0, in_ready 0 until next_frame.
REQ-027 {run=2,col=0x01}, no further data, 4 next_pixel -> underrun=1 after 3rd strobe, colour 0; STATS_EN build underrun_count=2.
REQ-028 next_frame asserted with next_pixel mid-run, FIFO holding 3 words -> FIFO empty, fetch_restart pulse one cycle later, state FILL, colour 0.
REQ-029 rstn low for one cycle mid-RUN -> all outputs 0 within same cycle; next_frame required before data accepted.

Source files
------------

// File: rtl/rle_stream_decoder.sv
// Run-length pixel stream decoder: buffers {run,colour} words, expands per next_pixel.
// Optional RLE_DECODER_STATS_EN adds a saturating underrun_count output.
module rle_stream_decoder #(
  parameter int COLOUR_BITS = 6,
  parameter int RUN_BITS    = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [RUN_BITS+COLOUR_BITS-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            next_frame,
  input  logic                            next_pixel,
  output logic [COLOUR_BITS-1:0]          colour,
  output logic                            fetch_restart,
  output logic                            underrun,
`ifdef RLE_DECODER_STATS_EN
  output logic [7:0]                      underrun_count,
`endif
  output logic                            frame_done
);

  localparam int W  = RUN_BITS + COLOUR_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_END  = 2'd3;

  localparam logic [RUN_BITS-1:0] RUN_ONE = 1;

  logic [1:0]          state;
  logic [W-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]         wp;
  logic [AW:0]         rp;
  logic [RUN_BITS-1:0] cnt;

  logic                empty;
  logic                full;
  logic                push;
  logic                want;
  logic                pop;
  logic                head_ok;
  logic                wr_fifo;
  logic                starve;
  logic [W-1:0]        head;
  logic [RUN_BITS-1:0] head_run;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  assign in_ready = !full &&
                    (state == S_FILL || state == S_RUN);

  assign push = in_valid && in_ready && !next_frame;

  // An empty buffer lets the incoming word pass straight to the run logic
  assign head     = empty ? in_data : mem[rp[AW-1:0]];
  assign head_ok  = !empty || push;
  assign head_run = head[W-1:COLOUR_BITS];

  always_comb begin
    want = 1'b0;
    if (!next_frame) begin
      unique case (1'b1)
        state == S_FILL: want = 1'b1;
        state == S_RUN:
          want = (cnt == '0) ||
                 (next_pixel && cnt == RUN_ONE);
        default: want = 1'b0;
      endcase
    end
  end

  assign pop     = want && head_ok;
  assign wr_fifo = push && !(empty && pop);

  assign starve = !next_frame && next_pixel &&
                  (state == S_FILL ||
                   (state == S_RUN && cnt == '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else if (next_frame) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_fifo)
        wp <= wp + 1'b1;
      if (pop && !empty)
        rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fifo)
      mem[wp[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      cnt           <= '0;
      colour        <= '0;
      fetch_restart <= 1'b0;
      underrun      <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      fetch_restart <= next_frame;
      if (next_frame) begin
        state      <= S_FILL;
        cnt        <= '0;
        colour     <= '0;
        underrun   <= 1'b0;
        frame_done <= 1'b0;
      end else begin
        if (starve)
          underrun <= 1'b1;
        if (pop) begin
          if (head_run == '0) begin
            state      <= S_END;
            frame_done <= 1'b1;
            colour     <= '0;
            cnt        <= '0;
          end else begin
            state  <= S_RUN;
            cnt    <= head_run;
            colour <= head[COLOUR_BITS-1:0];
          end
        end else if (state == S_RUN && next_pixel &&
                     cnt != '0) begin
          cnt <= cnt - 1'b1;
          // last pixel gone and nothing buffered
          if (cnt == RUN_ONE)
            colour <= '0;
        end
      end
    end
  end

`ifdef RLE_DECODER_STATS_EN
  logic [7:0] ucnt;

  assign underrun_count = ucnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ucnt <= '0;
    else if (next_frame)
      ucnt <= '0;
    else if (starve && ucnt != 8'hff)
      ucnt <= ucnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_rle_stream_decoder.sv
// Bench for rle_stream_decoder: pixel-list model checked every cycle
// plus directed literal expectations.
module tb_rle_stream_decoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        next_frame;
  logic        next_pixel;
  logic [5:0]  colour;
  logic        fetch_restart;
  logic        underrun;
  logic        frame_done;
`ifdef RLE_DECODER_STATS_EN
  logic [7:0]  underrun_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int pix[$];
  int und;
  int active;
  int pnf;

  rle_stream_decoder dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .next_frame    (next_frame),
    .next_pixel    (next_pixel),
    .colour        (colour),
    .fetch_restart (fetch_restart),
    .underrun      (underrun),
`ifdef RLE_DECODER_STATS_EN
    .underrun_count(underrun_count),
`endif
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] wd(int r, int c);
    logic [15:0] w;
    w = {r[9:0], c[5:0]};
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
  endtask

  task automatic send(int r, int c);
    int n;
    n = 0;
    in_data  = wd(r, c);
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready)
      chk("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic strobe(string nm, int exp);
    chk(nm, int'(colour), exp);
    next_pixel = 1'b1;
    tick();
    next_pixel = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    next_frame = 1'b0;
    next_pixel = 1'b0;
    fork
      begin
        int ec;
        int ed;
        int acc;
        int r;
        forever begin
          @(negedge clk);
          if (!rstn) begin
            pix.delete();
            und    = 0;
            active = 0;
            pnf    = 0;
          end
          ec = (pix.size() > 0 && pix[0] >= 0) ? pix[0] : 0;
          ed = (pix.size() > 0 && pix[0] < 0) ? 1 : 0;
          chk("m_colour", int'(colour), ec);
          chk("m_frame_done", int'(frame_done), ed);
          chk("m_underrun", int'(underrun), und);
          chk("m_fetch_restart", int'(fetch_restart), pnf);
          if (active == 0 || ed == 1)
            chk("m_in_ready_low", int'(in_ready), 0);
          if (rstn) begin
            acc = (in_valid && in_ready) ? 1 : 0;
            pnf = int'(next_frame);
            if (next_frame) begin
              pix.delete();
              und    = 0;
              active = 1;
            end else begin
              if (next_pixel && active == 1 && ed == 0) begin
                if (pix.size() == 0)
                  und = 1;
                else
                  void'(pix.pop_front());
              end
              if (acc == 1) begin
                r = int'(in_data[15:6]);
                if (r == 0)
                  pix.push_back(-1);
                else
                  repeat (r) pix.push_back(int'(in_data[5:0]));
              end
            end
          end
        end
      end
      begin
        tick();
        tick();
        chk("rst_colour", int'(colour), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_fetch_restart", int'(fetch_restart), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        rstn = 1'b1;
        tick();
        chk("idle_in_ready", int'(in_ready), 0);

        // two runs back to back
        frame();
        chk("nf_fetch_restart", int'(fetch_restart), 1);
        send(3, 'h2A);
        send(2, 'h15);
        strobe("s1_p0", 'h2A);
        strobe("s1_p1", 'h2A);
        strobe("s1_p2", 'h2A);
        strobe("s1_p3", 'h15);
        strobe("s1_p4", 'h15);
        chk("s1_underrun", int'(underrun), 0);

        // buffer fills, one pop frees a slot
        frame();
        send(1, 'h01);
        for (int i = 0; i < 4; i++) begin
          in_data  = wd(1, 'h10 + i);
          in_valid = 1'b1;
          chk("s2_rdy_fill", int'(in_ready), 1);
          tick();
        end
        in_data = wd(1, 'h14);
        chk("s2_rdy_full", int'(in_ready), 0);
        tick();
        chk("s2_rdy_full2", int'(in_ready), 0);
        next_pixel = 1'b1;
        tick();
        next_pixel = 1'b0;
        chk("s2_rdy_pop", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++)
          strobe("s2_seq", 'h10 + i);

        // end-of-frame marker
        frame();
        send(1, 'h3F);
        send(0, 'h00);
        strobe("s3_p0", 'h3F);
        chk("s3_done", int'(frame_done), 1);
        chk("s3_colour", int'(colour), 0);
        chk("s3_rdy", int'(in_ready), 0);
        in_data  = wd(2, 'h09);
        in_valid = 1'b1;
        tick();
        tick();
        chk("s3_rdy_held", int'(in_ready), 0);
        in_valid = 1'b0;
        frame();
        chk("s3_done_clr", int'(frame_done), 0);

        // starvation, then write-through recovery
        send(2, 'h01);
        strobe("s4_p0", 'h01);
        strobe("s4_p1", 'h01);
        chk("s4_und_exh", int'(underrun), 0);
        strobe("s4_p2", 0);
        chk("s4_und", int'(underrun), 1);
        strobe("s4_p3", 0);
`ifdef RLE_DECODER_STATS_EN
        chk("s4_ucount", int'(underrun_count), 2);
`endif
        send(2, 'h07);
        chk("s4_through", int'(colour), 'h07);

        // next_frame beats next_pixel mid-run
        frame();
        send(5, 'h0A);
        send(1, 'h0B);
        send(1, 'h0C);
        send(1, 'h0D);
        strobe("s5_p0", 'h0A);
        next_frame = 1'b1;
        next_pixel = 1'b1;
        tick();
        next_frame = 1'b0;
        next_pixel = 1'b0;
        chk("s5_colour", int'(colour), 0);
        chk("s5_restart", int'(fetch_restart), 1);
        chk("s5_und", int'(underrun), 0);
        chk("s5_rdy", int'(in_ready), 1);
        tick();
        chk("s5_restart_end", int'(fetch_restart), 0);
        strobe("s5_fill_px", 0);
        chk("s5_fill_und", int'(underrun), 1);
        send(2, 'h21);
        chk("s5_fresh", int'(colour), 'h21);

        // reset mid-run
        frame();
        send(4, 'h11);
        send(4, 'h22);
        strobe("s6_p0", 'h11);
        rstn = 1'b0;
        #1;
        chk("s6_colour", int'(colour), 0);
        chk("s6_rdy", int'(in_ready), 0);
        chk("s6_und", int'(underrun), 0);
        chk("s6_done", int'(frame_done), 0);
        tick();
        rstn     = 1'b1;
        in_data  = wd(3, 'h05);
        in_valid = 1'b1;
        tick();
        tick();
        chk("s6_idle_rdy", int'(in_ready), 0);
        chk("s6_no_restart", int'(fetch_restart), 0);
        in_valid = 1'b0;
        frame();
        chk("s6_restart", int'(fetch_restart), 1);
        send(3, 'h05);
        chk("s6_new", int'(colour), 'h05);
        tick();
        tick();
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
